// File: rtl/xm23_exec_unit.sv
// XM23 execute stage: registered ALU with PSW flag generation and a registered
// byte manipulator for immediate-byte moves. All outputs come straight from flops.
module xm23_exec_unit (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        alu_E,
    input  logic [5:0]  alu_op,
    input  logic [15:0] s_bus,
    input  logic [15:0] d_bus,
    input  logic        psw_update,
    input  logic        psw_load,
    input  logic [15:0] psw_in,
    input  logic        bm_E,
    input  logic [2:0]  bm_op,
    input  logic [15:0] bm_in,
    input  logic [7:0]  ImByte,
    output logic [15:0] alu_out,
    output logic [15:0] psw_out,
    output logic [15:0] bm_out
);

    localparam logic [4:0] OP_ADD  = 5'd0,  OP_ADDC = 5'd1,  OP_SUB  = 5'd2,  OP_SUBC = 5'd3;
    localparam logic [4:0] OP_DADD = 5'd4,  OP_CMP  = 5'd5,  OP_XOR  = 5'd6,  OP_AND  = 5'd7;
    localparam logic [4:0] OP_OR   = 5'd8,  OP_BIT  = 5'd9,  OP_BIC  = 5'd10, OP_BIS  = 5'd11;
    localparam logic [4:0] OP_MOV  = 5'd12, OP_SRA  = 5'd13, OP_RRC  = 5'd14, OP_SWPB = 5'd15;
    localparam logic [4:0] OP_SXT  = 5'd16;

    logic [15:0] alu_r, psw_r, bm_r;
    logic [4:0]  op_s;
    logic        byte_s, fbyte_s, c_in_s, cin_s, sub_s;
    logic [15:0] sx_s, raw_s, merged_s, alu_val_s, psw_nxt_s, bm_val_s, dadd_s;
    logic [16:0] sum_s;
    logic [4:0]  dig_s;
    logic [3:0]  dcar_s;
    logic        dc_s, carry8_s, setc_s, setv_s, setnz_s, c_val_s, v_val_s, n_s, z_s;

    // ALU datapath and next-flag computation
    always_comb begin
        op_s    = alu_op[4:0];
        byte_s  = alu_op[5];
        fbyte_s = byte_s && (op_s != OP_SWPB) && (op_s != OP_SXT);
        c_in_s  = psw_r[0];
        sub_s   = (op_s == OP_SUB) || (op_s == OP_SUBC) || (op_s == OP_CMP);
        sx_s    = sub_s ? ~s_bus : s_bus;
        case (op_s)
            OP_ADDC, OP_SUBC: cin_s = c_in_s;
            OP_SUB, OP_CMP:   cin_s = 1'b1;
            default:          cin_s = 1'b0;
        endcase
        sum_s    = {1'b0, d_bus} + {1'b0, sx_s} + {16'h0000, cin_s};
        // The low byte of the word sum equals the byte sum; recover the bit-7 carry-out.
        carry8_s = sum_s[8] ^ d_bus[8] ^ sx_s[8];

        dc_s   = c_in_s;
        dig_s  = 5'd0;
        dadd_s = 16'h0000;
        dcar_s = 4'h0;
        for (int i = 0; i < 4; i++) begin
            dig_s = {1'b0, d_bus[4*i +: 4]} + {1'b0, s_bus[4*i +: 4]} + {4'h0, dc_s};
            if (dig_s > 5'd9) begin
                dig_s = dig_s + 5'd6;
                dc_s  = 1'b1;
            end else begin
                dc_s  = 1'b0;
            end
            dadd_s[4*i +: 4] = dig_s[3:0];
            dcar_s[i]        = dc_s;
        end

        raw_s   = d_bus;
        setc_s  = 1'b0;
        setv_s  = 1'b0;
        setnz_s = 1'b0;
        c_val_s = c_in_s;
        v_val_s = psw_r[4];
        case (op_s)
            OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP: begin
                raw_s   = sum_s[15:0];
                setc_s  = 1'b1;
                setv_s  = 1'b1;
                setnz_s = 1'b1;
                c_val_s = byte_s ? carry8_s : sum_s[16];
                v_val_s = byte_s ? ((d_bus[7] == sx_s[7]) && (sum_s[7] != d_bus[7]))
                                 : ((d_bus[15] == sx_s[15]) && (sum_s[15] != d_bus[15]));
            end
            OP_DADD: begin
                raw_s   = dadd_s;
                setc_s  = 1'b1;
                setnz_s = 1'b1;
                c_val_s = byte_s ? dcar_s[1] : dcar_s[3];
            end
            OP_XOR, OP_AND, OP_OR, OP_BIT, OP_BIC, OP_BIS, OP_SWPB, OP_SXT: begin
                case (op_s)
                    OP_XOR:  raw_s = d_bus ^ s_bus;
                    OP_AND:  raw_s = d_bus & s_bus;
                    OP_OR:   raw_s = d_bus | s_bus;
                    OP_BIT:  raw_s = d_bus & s_bus;
                    OP_BIC:  raw_s = d_bus & ~s_bus;
                    OP_BIS:  raw_s = d_bus | s_bus;
                    OP_SWPB: raw_s = {d_bus[7:0], d_bus[15:8]};
                    default: raw_s = {{8{d_bus[7]}}, d_bus[7:0]};
                endcase
                setv_s  = 1'b1;
                setnz_s = 1'b1;
                v_val_s = 1'b0;
            end
            OP_MOV: begin
                raw_s = s_bus;
            end
            OP_SRA, OP_RRC: begin
                if (byte_s) begin
                    raw_s = {d_bus[15:8], (op_s == OP_RRC) ? c_in_s : d_bus[7], d_bus[7:1]};
                end else begin
                    raw_s = {(op_s == OP_RRC) ? c_in_s : d_bus[15], d_bus[15:1]};
                end
                setc_s  = 1'b1;
                setnz_s = 1'b1;
                c_val_s = d_bus[0];
            end
            default: begin
                raw_s = d_bus;
            end
        endcase

        merged_s  = fbyte_s ? {d_bus[15:8], raw_s[7:0]} : raw_s;
        alu_val_s = ((op_s == OP_CMP) || (op_s == OP_BIT)) ? d_bus : merged_s;
        n_s       = fbyte_s ? merged_s[7] : merged_s[15];
        z_s       = fbyte_s ? (merged_s[7:0] == 8'h00) : (merged_s == 16'h0000);
        psw_nxt_s = {psw_r[15:5],
                     setv_s  ? v_val_s : psw_r[4],
                     psw_r[3],
                     setnz_s ? n_s     : psw_r[2],
                     setnz_s ? z_s     : psw_r[1],
                     setc_s  ? c_val_s : psw_r[0]};
    end

    // Byte manipulator result selection
    always_comb begin
        case (bm_op)
            3'd0:    bm_val_s = {bm_in[15:8], ImByte};
            3'd1:    bm_val_s = {8'h00, ImByte};
            3'd2:    bm_val_s = {8'hFF, ImByte};
            3'd3:    bm_val_s = {ImByte, bm_in[7:0]};
            default: bm_val_s = bm_in;
        endcase
    end

    // Output and PSW registers; a PSW load overrides an ALU flag update
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            alu_r <= 16'h0000;
            psw_r <= 16'h0000;
            bm_r  <= 16'h0000;
        end else begin
            if (alu_E) begin
                alu_r <= alu_val_s;
            end
            if (bm_E) begin
                bm_r <= bm_val_s;
            end
            if (psw_load) begin
                psw_r <= psw_in;
            end else if (alu_E && psw_update) begin
                psw_r <= psw_nxt_s;
            end
        end
    end

    assign alu_out = alu_r;
    assign psw_out = psw_r;
    assign bm_out  = bm_r;

endmodule

// File: tb/tb_xm23_exec_unit.sv
// Directed self-checking bench for xm23_exec_unit with hand-computed vectors.
module tb_xm23_exec_unit;

    logic        Clock, Reset_n, alu_E, psw_update, psw_load, bm_E;
    logic [5:0]  alu_op;
    logic [15:0] s_bus, d_bus, psw_in, bm_in, alu_out, psw_out, bm_out;
    logic [2:0]  bm_op;
    logic [7:0]  ImByte;
    int checks = 0;
    int errors = 0;

    xm23_exec_unit dut (
        .Clock(Clock), .Reset_n(Reset_n), .alu_E(alu_E), .alu_op(alu_op),
        .s_bus(s_bus), .d_bus(d_bus), .psw_update(psw_update), .psw_load(psw_load),
        .psw_in(psw_in), .bm_E(bm_E), .bm_op(bm_op), .bm_in(bm_in), .ImByte(ImByte),
        .alu_out(alu_out), .psw_out(psw_out), .bm_out(bm_out)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic alu_step(input logic [5:0] op, input logic [15:0] d, input logic [15:0] s,
                            input logic upd);
        alu_E = 1'b1; alu_op = op; d_bus = d; s_bus = s; psw_update = upd;
        @(posedge Clock); #1;
        alu_E = 1'b0; psw_update = 1'b0; psw_load = 1'b0;
    endtask

    task automatic chk_alu(input string name, input logic [15:0] exp_res, input logic [15:0] exp_psw);
        checks++;
        if (alu_out !== exp_res) begin
            errors++;
            $display("FAIL %s result: got %h expected %h", name, alu_out, exp_res);
        end
        checks++;
        if (psw_out !== exp_psw) begin
            errors++;
            $display("FAIL %s psw: got %h expected %h", name, psw_out, exp_psw);
        end
    endtask

    task automatic test_reset;
        Reset_n = 1'b0;
        #12;
        checks++;
        if ({alu_out, psw_out, bm_out} !== 48'h0) begin
            errors++;
            $display("FAIL reset: got %h %h %h expected 0000 0000 0000", alu_out, psw_out, bm_out);
        end
        Reset_n = 1'b1;
        @(posedge Clock); #1;
    endtask

    task automatic test_add;
        alu_step(6'd0, 16'h7FFF, 16'h0001, 1'b1);
        chk_alu("add_overflow", 16'h8000, 16'h0014);
    endtask

    task automatic test_sub;
        alu_step(6'd2, 16'h0005, 16'h0005, 1'b1);
        chk_alu("sub_zero", 16'h0000, 16'h0003);
        alu_step(6'd3, 16'h0003, 16'h0001, 1'b1);
        chk_alu("subc", 16'h0002, 16'h0001);
    endtask

    task automatic test_byte_add;
        alu_step(6'h20, 16'h12FF, 16'h0001, 1'b1);
        chk_alu("byte_add", 16'h1200, 16'h0003);
        alu_step(6'd1, 16'h0000, 16'h0000, 1'b1);
        chk_alu("addc_chain", 16'h0001, 16'h0000);
    endtask

    task automatic test_dadd;
        alu_step(6'd4, 16'h0999, 16'h0001, 1'b1);
        chk_alu("dadd_ripple", 16'h1000, 16'h0000);
        alu_step(6'd4, 16'h9999, 16'h0001, 1'b1);
        chk_alu("dadd_wrap", 16'h0000, 16'h0003);
    endtask

    task automatic test_rrc_mov;
        alu_step(6'd14, 16'h0001, 16'h0000, 1'b1);
        chk_alu("rrc", 16'h8000, 16'h0005);
        alu_step(6'd12, 16'h0000, 16'h1234, 1'b1);
        chk_alu("mov_noflags", 16'h1234, 16'h0005);
    endtask

    task automatic test_psw_load;
        psw_load = 1'b1; psw_in = 16'h0008;
        alu_step(6'd0, 16'h7FFF, 16'h0001, 1'b1);
        chk_alu("psw_load_wins", 16'h8000, 16'h0008);
    endtask

    task automatic test_hold;
        alu_op = 6'd0; d_bus = 16'hFFFF; s_bus = 16'h0001; psw_update = 1'b1; alu_E = 1'b0;
        @(posedge Clock); #1;
        psw_update = 1'b0;
        chk_alu("alu_disabled_hold", 16'h8000, 16'h0008);
        alu_step(6'd0, 16'h0001, 16'h0001, 1'b1);
        chk_alu("slp_preserved", 16'h0002, 16'h0008);
    endtask

    task automatic test_logic;
        alu_step(6'd7, 16'hF0F0, 16'h0FF0, 1'b1);
        chk_alu("and", 16'h00F0, 16'h0008);
        alu_step(6'd16, 16'h0080, 16'h0000, 1'b1);
        chk_alu("sxt", 16'hFF80, 16'h000C);
        alu_step(6'd15, 16'h1234, 16'h0000, 1'b1);
        chk_alu("swpb", 16'h3412, 16'h0008);
        alu_step(6'h26, 16'hAB0F, 16'h000F, 1'b1);
        chk_alu("byte_xor_zero", 16'hAB00, 16'h000A);
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp_bm [5];
        exp_bm[0] = 16'hAB34; exp_bm[1] = 16'h0034; exp_bm[2] = 16'hFF34;
        exp_bm[3] = 16'h34CD; exp_bm[4] = 16'hABCD;
        bm_in = 16'hABCD; ImByte = 8'h34; bm_E = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bm_op = (i == 4) ? 3'd7 : 3'(i);
            @(posedge Clock); #1;
            checks++;
            if (bm_out !== exp_bm[i]) begin
                errors++;
                $display("FAIL bm_op%0d: got %h expected %h", bm_op, bm_out, exp_bm[i]);
            end
        end
        bm_E = 1'b0; bm_op = 3'd1;
        @(posedge Clock); #1;
        checks++;
        if (bm_out !== 16'hABCD) begin
            errors++;
            $display("FAIL bm_hold: got %h expected ABCD", bm_out);
        end
        bm_E = 1'b1; bm_op = 3'd3; ImByte = 8'h77;
        alu_step(6'd12, 16'h0000, 16'h5555, 1'b1);
        bm_E = 1'b0;
        chk_alu("alu_with_bm", 16'h5555, 16'h000A);
        checks++;
        if (bm_out !== 16'h77CD) begin
            errors++;
            $display("FAIL bm_with_alu: got %h expected 77CD", bm_out);
        end
    endtask

    task automatic test_reset_async;
        #2;
        Reset_n = 1'b0;
        #1;
        checks++;
        if ({alu_out, psw_out, bm_out} !== 48'h0) begin
            errors++;
            $display("FAIL async_reset: got %h %h %h expected 0000 0000 0000", alu_out, psw_out, bm_out);
        end
        #2;
        Reset_n = 1'b1;
    endtask

    initial begin
        Reset_n = 1'b0; alu_E = 1'b0; alu_op = 6'd0; s_bus = 16'h0; d_bus = 16'h0;
        psw_update = 1'b0; psw_load = 1'b0; psw_in = 16'h0; bm_E = 1'b0; bm_op = 3'd0;
        bm_in = 16'h0; ImByte = 8'h0;
        test_reset;
        test_add;
        test_sub;
        test_byte_add;
        test_dadd;
        test_rrc_mov;
        test_psw_load;
        test_hold;
        test_logic;
        test_back_to_back;
        test_reset_async;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xm23_exec_unit.md
# xm23_exec_unit

Execute-stage datapath for the XM23 CPU: a registered ALU with PSW flag generation plus a registered byte manipulator for immediate-byte moves. It sits between the register-file buses (`s_bus`, `d_bus`) and the control unit, which supplies operation codes and enables and writes results back over the data bus. One clock; all outputs are registered.

## Interface
- No parameters; data width fixed at 16 bits.
- `Clock`  in  1  system clock; rising edge active.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `alu_E`  in  1  ALU enable; result register loads when high.
- `alu_op`  in  6  `[4:0]` operation code, `[5]` byte mode (1 = byte, 0 = word).
- `s_bus`  in  16  source operand.
- `d_bus`  in  16  destination operand.
- `psw_update`  in  1  allow the ALU operation to modify flags.
- `psw_load`  in  1  load `psw_in` into the PSW register.
- `psw_in`  in  16  PSW load value (e.g. from the MDR).
- `bm_E`  in  1  byte-manipulator enable.
- `bm_op`  in  3  byte-manipulator operation.
- `bm_in`  in  16  register operand for byte moves.
- `ImByte`  in  8  immediate byte.
- `alu_out`  out  16  registered ALU result.
- `psw_out`  out  16  PSW register: bit0 C, bit1 Z, bit2 N, bit3 SLP, bit4 V.
- `bm_out`  out  16  registered byte-manipulator result.

## Operation
- ALU ops, D = `d_bus`, S = `s_bus`:
  - 0 ADD: D+S.
  - 1 ADDC: D+S+C.
  - 2 SUB: D+~S+1.
  - 3 SUBC: D+~S+C.
  - 4 DADD: BCD add per nibble, with C as carry-in.
  - 5 CMP: same as SUB for flags only.
  - 6 XOR.
  - 7 AND.
  - 8 OR.
  - 9 BIT: D&S for flags only.
  - 10 BIC: D&~S.
  - 11 BIS: D|S.
  - 12 MOV: S.
  - 13 SRA: arithmetic right shift of D by 1.
  - 14 RRC: rotate D right through C.
  - 15 SWPB: swap the bytes of D.
  - 16 SXT: sign-extend D[7:0].
  - Codes 17–31: result is D, flags unchanged.
- CMP and BIT: `alu_out` = D (no write-back value).
- Byte mode (`alu_op[5]`=1):
  - Arithmetic and logic operate on bits [7:0] only.
  - Result is {D[15:8], result[7:0]}.
  - Flags are taken from the 8-bit result: N = bit7, carry/overflow out of bit7.
  - SWPB and SXT ignore byte mode.
- Flags, applied only when `alu_E` and `psw_update` are both high:
  - ADD/ADDC/SUB/SUBC/CMP: C = carry out, V = signed overflow, N = MSB, Z = (result==0).
  - DADD: C = decimal carry out of the top digit; N and Z from the result; V unchanged.
  - XOR/AND/OR/BIT/BIC/BIS/SWPB/SXT: N and Z from the result; V = 0; C unchanged.
  - SRA: C = D bit0 shifted out; N and Z from the result; V unchanged.
  - RRC: new MSB = old C; C = old D bit0; N and Z from the result; V unchanged.
  - MOV: no flag change.
- PSW bits other than C/Z/N/V (including SLP) change only via `psw_load`.
- Byte-manipulator ops:
  - 0 MOVL: {bm_in[15:8], ImByte}.
  - 1 MOVLZ: {8'h00, ImByte}.
  - 2 MOVLS: {8'hFF, ImByte}.
  - 3 MOVH: {ImByte, bm_in[7:0]}.
  - 4–7: `bm_in` unchanged.

## Timing
- Reset (asynchronous, while `Reset_n`=0): `alu_out`=0, `bm_out`=0, `psw_out`=0.
- Reset asserted mid-operation discards any pending result immediately.
- Latency is one cycle: inputs sampled at a rising edge appear on the outputs after that edge.
- `alu_E`=0: `alu_out` holds; flags do not change.
- `bm_E`=0: `bm_out` holds.
- `psw_load` and an ALU flag update in the same cycle: `psw_load` wins; `psw_out` = `psw_in`.
- ALU and byte manipulator are independent and may both be enabled in the same cycle.
- Carry-in (C for ADDC/SUBC/DADD/RRC) is taken from the current `psw_out` value, so back-to-back ADD then ADDC chains correctly with no stall.
- Arithmetic wraps modulo 2^16 (2^8 in byte mode).

## Test plan
- Word ADD with 7FFF + 0001 → `alu_out`=8000; N=1, V=1, C=0, Z=0, one cycle after the edge.
- Word SUB with D=0005, S=0005 → 0000; Z=1, C=1, V=0. Then SUBC with C=1, D=0003, S=0001 → 0002.
- Byte ADD with D=12FF, S=0001 → 1200; C=1, Z=1, N=0. Then ADDC word 0000+0000 → 0001.
- DADD with D=0999, S=0001, C=0 → 1000, C=0; then D=9999, S=0001 → 0000, C=1, Z=1.
- RRC with D=0001, C=1 → 8000, C=1, N=1. MOV with `psw_update`=1 leaves the PSW unchanged. `psw_load` with `psw_in`=0008 in the same cycle as a flag-setting ADD → `psw_out`=0008.
- Byte manipulator with `bm_in`=ABCD, `ImByte`=34:
  - MOVL → AB34.
  - MOVLZ → 0034.
  - MOVLS → FF34.
  - MOVH → 34CD.
  - Drop `Reset_n` mid-sequence → all outputs 0000 without waiting for a clock edge.
